// File: rtl/actor_token_fifo.sv
// actor_token_fifo: order-preserving first-word-fall-through token queue placed
// between the Out port of one actor and the In port of the next.
//   Write side (producer -> queue): WR_SEND, WR_DATA, WR_COUNT in; WR_ACK, WR_RDY out.
//   Read side  (queue -> consumer): RD_SEND, RD_DATA, RD_COUNT out; RD_ACK in.
//   ERR: sticky protocol-violation flag, cleared only by RESET.
//   CLK rising edge; RESET asynchronous, active-high.
module actor_token_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_SEND,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic [CNT_W-1:0] WR_COUNT,
  output logic             WR_ACK,
  output logic             WR_RDY,
  output logic             RD_SEND,
  output logic [WIDTH-1:0] RD_DATA,
  output logic [CNT_W-1:0] RD_COUNT,
  input  logic             RD_ACK,
  output logic             ERR
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_TOK = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          wr_rdy_q, wr_rdy_d;
  logic          err_q,    err_d;

  logic push;
  logic pop;
  logic not_empty;

  // Handshake decode and next-state for pointers, occupancy, ready and error.
  always_comb begin
    not_empty = (count_q != '0);
    push      = WR_SEND & wr_rdy_q;
    pop       = RD_ACK & not_empty;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Ready looks one cycle ahead, so a full queue refuses a push even when
    // the consumer pops in the same cycle.
    wr_rdy_d = (count_d < DEPTH_C);

    if (WR_SEND & ~wr_rdy_q)               err_d = 1'b1;
    if (RD_ACK & ~not_empty)               err_d = 1'b1;
    if (WR_SEND & (WR_COUNT != ONE_TOK))   err_d = 1'b1;
  end

  // Control state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_rdy_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_rdy_q <= wr_rdy_d;
      err_q    <= err_d;
    end
  end

  // Token storage, not reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= WR_DATA;
  end

  assign WR_ACK   = push;
  assign WR_RDY   = wr_rdy_q;
  assign RD_SEND  = not_empty;
  assign RD_DATA  = mem[rd_ptr_q];
  assign RD_COUNT = CNT_W'(count_q);
  assign ERR      = err_q;

endmodule

// File: tb/tb_actor_token_fifo.sv
// Directed bench for actor_token_fifo: reset, fill, drain, streaming across
// pointer wrap, protocol violations and mid-operation reset.
module tb_actor_token_fifo;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DEPTH      = 16;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             WR_SEND;
  logic [WIDTH-1:0] WR_DATA;
  logic [CNT_W-1:0] WR_COUNT;
  logic             WR_ACK;
  logic             WR_RDY;
  logic             RD_SEND;
  logic [WIDTH-1:0] RD_DATA;
  logic [CNT_W-1:0] RD_COUNT;
  logic             RD_ACK;
  logic             ERR;

  int n_cmp = 0;
  int n_bad = 0;

  actor_token_fifo #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_SEND(WR_SEND), .WR_DATA(WR_DATA), .WR_COUNT(WR_COUNT),
    .WR_ACK(WR_ACK), .WR_RDY(WR_RDY),
    .RD_SEND(RD_SEND), .RD_DATA(RD_DATA), .RD_COUNT(RD_COUNT),
    .RD_ACK(RD_ACK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Short reset; WR_RDY is high on return.
  task automatic do_reset();
    RESET = 1'b1;
    WR_SEND = 1'b0; RD_ACK = 1'b0; WR_COUNT = 16'd1; WR_DATA = '0;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic push_n(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      WR_SEND = 1'b1; WR_DATA = base + 16'(i); WR_COUNT = 16'd1;
      #1;
      chk($sformatf("push_ack[%0d]", i), 32'(WR_ACK), 32'd1);
      tick();
    end
    WR_SEND = 1'b0;
  endtask

  task automatic drain_n(input logic [15:0] base, input int n, input string tag);
    RD_ACK = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("%s_data[%0d]", tag, i), 32'(RD_DATA), 32'(base + 16'(i)));
      if (i == 1) chk($sformatf("%s_rdy_after_pop", tag), 32'(WR_RDY), 32'd1);
      tick();
    end
    RD_ACK = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1 reset
    RESET = 1'b1; WR_SEND = 1'b0; RD_ACK = 1'b0; WR_COUNT = 16'd1; WR_DATA = '0;
    repeat (3) tick();
    chk("rst_wr_rdy",   32'(WR_RDY),   32'd0);
    chk("rst_rd_send",  32'(RD_SEND),  32'd0);
    chk("rst_rd_count", 32'(RD_COUNT), 32'd0);
    chk("rst_err",      32'(ERR),      32'd0);
    RESET = 1'b0;
    #1;
    chk("rel_wr_rdy_before_edge", 32'(WR_RDY), 32'd0);
    tick();
    chk("rel_wr_rdy", 32'(WR_RDY), 32'd1);

    // T2 fill
    push_n(16'h0001, 16);
    #1;
    chk("full_wr_rdy",   32'(WR_RDY),   32'd0);
    chk("full_rd_count", 32'(RD_COUNT), 32'd16);
    chk("full_rd_send",  32'(RD_SEND),  32'd1);
    chk("full_err",      32'(ERR),      32'd0);

    // T3 drain
    drain_n(16'h0001, 16, "drain");
    chk("drain_rd_send",  32'(RD_SEND),  32'd0);
    chk("drain_rd_count", 32'(RD_COUNT), 32'd0);
    chk("drain_err",      32'(ERR),      32'd0);

    // T4 streaming: prime one token, then push and pop together for 40 cycles
    push_n(16'h0100, 1);
    WR_SEND = 1'b1; RD_ACK = 1'b1;
    for (int i = 0; i < 40; i++) begin
      WR_DATA = 16'h0101 + 16'(i);
      #1;
      chk($sformatf("stream_data[%0d]", i),  32'(RD_DATA),  32'(16'h0100 + 16'(i)));
      chk($sformatf("stream_count[%0d]", i), 32'(RD_COUNT), 32'd1);
      tick();
    end
    WR_SEND = 1'b0;
    #1;
    chk("stream_last", 32'(RD_DATA), 32'h0128);
    tick();
    RD_ACK = 1'b0;
    chk("stream_end_count", 32'(RD_COUNT), 32'd0);
    chk("stream_err",       32'(ERR),      32'd0);

    // T5a write while full
    do_reset();
    push_n(16'h0200, 16);
    WR_SEND = 1'b1; WR_DATA = 16'hDEAD;
    #1;
    chk("ovf_ack", 32'(WR_ACK), 32'd0);
    tick();
    WR_SEND = 1'b0;
    chk("ovf_err",   32'(ERR),      32'd1);
    chk("ovf_count", 32'(RD_COUNT), 32'd16);
    drain_n(16'h0200, 16, "ovf_drain");
    chk("ovf_drain_count", 32'(RD_COUNT), 32'd0);
    repeat (3) tick();
    chk("ovf_err_sticky", 32'(ERR), 32'd1);

    // T5b read while empty
    do_reset();
    chk("udf_err_clear", 32'(ERR), 32'd0);
    RD_ACK = 1'b1;
    tick();
    RD_ACK = 1'b0;
    chk("udf_err",     32'(ERR),      32'd1);
    chk("udf_count",   32'(RD_COUNT), 32'd0);
    chk("udf_rd_send", 32'(RD_SEND),  32'd0);
    repeat (3) tick();
    chk("udf_err_sticky", 32'(ERR), 32'd1);

    // T5c bad WR_COUNT still stores the token
    do_reset();
    chk("cnt_err_clear", 32'(ERR), 32'd0);
    WR_SEND = 1'b1; WR_DATA = 16'h0BEE; WR_COUNT = 16'd2;
    #1;
    chk("cnt_ack", 32'(WR_ACK), 32'd1);
    tick();
    WR_SEND = 1'b0; WR_COUNT = 16'd1;
    chk("cnt_err",   32'(ERR),      32'd1);
    chk("cnt_count", 32'(RD_COUNT), 32'd1);
    chk("cnt_data",  32'(RD_DATA),  32'h0BEE);
    repeat (3) tick();
    chk("cnt_err_sticky", 32'(ERR), 32'd1);

    // T6 reset mid-operation
    do_reset();
    chk("mid_err_clear", 32'(ERR), 32'd0);
    push_n(16'h0300, 5);
    chk("mid_count_pre", 32'(RD_COUNT), 32'd5);
    RESET = 1'b1;
    #1;
    chk("mid_rd_send",  32'(RD_SEND),  32'd0);
    chk("mid_rd_count", 32'(RD_COUNT), 32'd0);
    chk("mid_wr_rdy",   32'(WR_RDY),   32'd0);
    tick();
    RESET = 1'b0;
    tick();
    chk("mid_wr_rdy_back", 32'(WR_RDY), 32'd1);
    push_n(16'h0ABC, 1);
    chk("mid_rd_send_after", 32'(RD_SEND),  32'd1);
    chk("mid_data_after",    32'(RD_DATA),  32'h0ABC);
    chk("mid_count_after",   32'(RD_COUNT), 32'd1);
    chk("mid_err_after",     32'(ERR),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
